// File: rtl/twiddle_gen.sv
// -----------------------------------------------------------------------------
// twiddle_gen
//
// Quarter-wave cosine/sine generator. Delivers a signed (cos, sin) pair per
// phase point for the FFT butterflies and the display-side windowing. A full
// circle has N = 2^ADDR_W points. Full scale is A = 2^(DATA_W-1) - 1.
//
// Only one quarter-wave of cosine is stored: Q+1 entries, where Q = N/4 and
// entry i = round(A*cos(2*pi*i/N)). The other three quadrants and the sine
// are rebuilt from two table reads (C[r] and C[Q-r]) plus sign flips. The
// table is symmetric at +/-A, so negation never overflows.
//
// The table contents are computed at elaboration by a fixed-point constant
// function. This avoids depending on an external image file, and the
// contents follow the same defining formula as the former hex image.
//
// Requests come either as direct phases (in_valid/addr) or as a sweep
// command (start with addr/step/len). A sweep then issues one phase per
// cycle without further input. Results leave through a fixed pipeline: a
// request sampled at edge k is on the outputs after edge k+3.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   direct-mode request; addr is sampled while high
//   addr       in   direct phase, or sweep start phase when start is high
//   start      in   one-cycle sweep command (ignored while busy or len==0)
//   step       in   sweep phase increment, sampled with start
//   len        in   number of sweep samples, sampled with start
//   cos_out    out  signed A*cos(2*pi*phase/N)
//   sin_out    out  signed A*sin(2*pi*phase/N)
//   out_valid  out  cos_out/sin_out carry a new sample this cycle
//   out_last   out  final sample of a sweep (only ever with out_valid)
//   busy       out  sweep in progress
// -----------------------------------------------------------------------------
module twiddle_gen #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic              start,
   input  logic [ADDR_W-1:0] step,
   input  logic [ADDR_W:0]   len,
   output logic [DATA_W-1:0] cos_out,
   output logic [DATA_W-1:0] sin_out,
   output logic              out_valid,
   output logic              out_last,
   output logic              busy
);

   localparam int Q    = 1 << (ADDR_W - 2);
   // Table addresses run 0..Q inclusive, so one bit wider than the residue.
   localparam int RA_W = ADDR_W - 1;

   // round(A*cos(pi/2 * idx/Q)) using a Q30 Taylor series. The products stay
   // within 64 bits for the whole first quadrant and for DATA_W up to 32.
   function automatic logic signed [DATA_W-1:0] quarter_cos(input longint idx);
      longint one;
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint amp;
      longint prod;
      one  = 64'sd1 <<< 30;
      // pi/2 in Q30
      x    = (64'sd1686629713 * idx) / longint'(Q);
      x2   = (x * x) >>> 30;
      term = one;
      acc  = one;
      for (longint k = 1; k <= 12; k++) begin
         term = -((term * x2) >>> 30) / ((2 * k - 1) * (2 * k));
         acc  = acc + term;
      end
      amp  = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
      prod = acc * amp + (one >>> 1);
      return DATA_W'(prod >>> 30);
   endfunction

   function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] v);
      return -v;
   endfunction

   logic signed [DATA_W-1:0] rom [0:Q];

   for (genvar g = 0; g <= Q; g++) begin : g_rom
      localparam logic signed [DATA_W-1:0] ENTRY = quarter_cos(longint'(g));
      assign rom[g] = ENTRY;
   end

   // ---------------------------------------------------------------------------
   // Request/sweep control
   // ---------------------------------------------------------------------------
   typedef enum logic {IDLE, SWEEP} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   phase, phase_nxt;
   logic [ADDR_W-1:0]   stride, stride_nxt;
   logic [ADDR_W:0]     remain, remain_nxt;
   logic                iss_vld;
   logic                iss_last;
   logic [ADDR_W-1:0]   iss_phase;

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      stride_nxt = stride;
      remain_nxt = remain;
      iss_vld    = 1'b0;
      iss_last   = 1'b0;
      iss_phase  = addr;
      case (state)
         IDLE: begin
            // start has priority; a simultaneous direct request is dropped,
            // and a zero-length sweep is dropped as well.
            if (start) begin
               if (len != '0) begin
                  phase_nxt  = addr;
                  stride_nxt = step;
                  remain_nxt = len;
                  state_nxt  = SWEEP;
               end
            end else if (in_valid) begin
               iss_vld = 1'b1;
            end
         end
         SWEEP: begin
            iss_vld    = 1'b1;
            iss_phase  = phase;
            phase_nxt  = phase + stride;
            remain_nxt = remain - (ADDR_W+1)'(1);
            if (remain == (ADDR_W+1)'(1)) begin
               iss_last  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Sweep parameters are only consulted in SWEEP, after being loaded.
   always_ff @(posedge clk) begin
      phase  <= phase_nxt;
      stride <= stride_nxt;
      remain <= remain_nxt;
   end

   assign busy = (state == SWEEP);

   // ---------------------------------------------------------------------------
   // p0: issued phase with its valid/last tags
   // ---------------------------------------------------------------------------
   logic                vld_p0, last_p0;
   logic [ADDR_W-1:0]   phase_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end else begin
         vld_p0  <= iss_vld;
         last_p0 <= iss_last;
      end
   end

   always_ff @(posedge clk) phase_p0 <= iss_phase;

   // ---------------------------------------------------------------------------
   // p1 (S1): quadrant and the two table addresses r and Q-r
   // ---------------------------------------------------------------------------
   logic                vld_p1, last_p1;
   logic [1:0]          quad_p1;
   logic [RA_W-1:0]     ra_p1, rb_p1;
   logic [RA_W-1:0]     res_p0;

   assign res_p0 = {1'b0, phase_p0[ADDR_W-3:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
      end
   end

   always_ff @(posedge clk) begin
      quad_p1 <= phase_p0[ADDR_W-1 -: 2];
      ra_p1   <= res_p0;
      rb_p1   <= RA_W'(Q) - res_p0;
   end

   // ---------------------------------------------------------------------------
   // p2 (S2): both table reads, C[r] and C[Q-r]
   // ---------------------------------------------------------------------------
   logic                      vld_p2, last_p2;
   logic [1:0]                quad_p2;
   logic signed [DATA_W-1:0]  ca_p2, cb_p2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
      end else begin
         vld_p2  <= vld_p1;
         last_p2 <= last_p1;
      end
   end

   always_ff @(posedge clk) begin
      quad_p2 <= quad_p1;
      ca_p2   <= rom[ra_p1];
      cb_p2   <= rom[rb_p1];
   end

   // ---------------------------------------------------------------------------
   // p3 (S3): quadrant fold into signed cos/sin.
   // The output registers hold their value on idle cycles and are cleared by
   // reset so the outputs read zero while reset_n is low.
   // ---------------------------------------------------------------------------
   logic                      vld_p3, last_p3;
   logic signed [DATA_W-1:0]  cos_p3, sin_p3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p3  <= 1'b0;
         last_p3 <= 1'b0;
         cos_p3  <= '0;
         sin_p3  <= '0;
      end else begin
         vld_p3  <= vld_p2;
         last_p3 <= last_p2;
         if (vld_p2) begin
            case (quad_p2)
               2'd0: begin
                  cos_p3 <= ca_p2;
                  sin_p3 <= cb_p2;
               end
               2'd1: begin
                  cos_p3 <= neg(cb_p2);
                  sin_p3 <= ca_p2;
               end
               2'd2: begin
                  cos_p3 <= neg(ca_p2);
                  sin_p3 <= neg(cb_p2);
               end
               default: begin
                  cos_p3 <= cb_p2;
                  sin_p3 <= neg(ca_p2);
               end
            endcase
         end
      end
   end

   assign cos_out   = cos_p3;
   assign sin_out   = sin_p3;
   assign out_valid = vld_p3;
   assign out_last  = last_p3;

endmodule

// File: tb/tb_twiddle_gen.sv
// -----------------------------------------------------------------------------
// tb_twiddle_gen
//
// Bench for twiddle_gen with default parameters (N = 1024, A = 131071).
// The reference model expands every accepted command into a list of
// expected output beats: the beat cycle, the phase, and the last flag.
// These come from the command timing rules. Values come from real
// trigonometry, or from exact constants for the table vectors.
// -----------------------------------------------------------------------------
module tb_twiddle_gen;

   localparam int AW = 10;
   localparam int DW = 18;
   localparam int N  = 1 << AW;
   localparam int A  = (1 << (DW - 1)) - 1;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 in_valid;
   logic                 start;
   logic [AW-1:0]        addr;
   logic [AW-1:0]        step;
   logic [AW:0]          len;
   logic signed [DW-1:0] cos_out;
   logic signed [DW-1:0] sin_out;
   logic                 out_valid;
   logic                 out_last;
   logic                 busy;

   twiddle_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .addr      (addr),
      .start     (start),
      .step      (step),
      .len       (len),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int ph;
      bit last;
      bit ex;
      int ce;
      int se;
   } beat_t;

   typedef struct {
      int addr;
      int cos_e;
      int sin_e;
   } vec_t;

   beat_t exp_q[$];
   int    cyc     = 0;
   int    n_vec   = 0;
   int    n_err   = 0;
   int    busy_lo = 1;
   int    busy_hi = 0;
   real   hold_c  = 0.0;
   real   hold_s  = 0.0;
   bit    mon_on  = 1'b0;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   function automatic real ideal(input int p, input bit want_sin);
      real ang;
      ang = 2.0 * 3.14159265358979323846 * real'(p) / real'(N);
      return want_sin ? real'(A) * $sin(ang) : real'(A) * $cos(ang);
   endfunction

   function automatic bit near(input int v, input real r);
      real d;
      d = real'(v) - r;
      return (d <= 1.0) && (d >= -1.0);
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Drive one cycle of inputs, sampled on the next rising edge, and record
   // what the generator must produce in response.
   task automatic apply(input bit iv, input int a, input bit st, input int stp, input int ln,
                        input bit ex, input int ce, input int se);
      beat_t b;
      int    k;
      bit    in_sweep;
      in_sweep = (cyc >= busy_lo) && (cyc <= busy_hi);
      if (!in_sweep && st) begin
         if (ln != 0) begin
            k       = cyc + 1;
            busy_lo = k;
            busy_hi = k + ln - 1;
            for (int j = 0; j < ln; j++) begin
               b.cyc  = k + 4 + j;
               b.ph   = (a + j * stp) % N;
               b.last = (j == ln - 1);
               b.ex   = 1'b0;
               b.ce   = 0;
               b.se   = 0;
               exp_q.push_back(b);
            end
         end
      end else if (!in_sweep && iv) begin
         b.cyc  = cyc + 4;
         b.ph   = a % N;
         b.last = 1'b0;
         b.ex   = ex;
         b.ce   = ce;
         b.se   = se;
         exp_q.push_back(b);
      end
      in_valid = iv;
      addr     = AW'(a);
      start    = st;
      step     = AW'(stp);
      len      = (AW+1)'(ln);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic direct(input int a);
      apply(1'b1, a, 1'b0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic sweep(input int a, input int stp, input int ln);
      apply(1'b0, a, 1'b1, stp, ln, 1'b0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(cos_out == '0,     {tag, "_cos"},       cos_out,   0);
      chk(sin_out == '0,     {tag, "_sin"},       sin_out,   0);
      chk(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
      chk(out_last == 1'b0,  {tag, "_out_last"},  out_last,  0);
      chk(busy == 1'b0,      {tag, "_busy"},      busy,      0);
   endtask

   // Output monitor: one check set per cycle, sampled mid-cycle.
   beat_t mon_e;
   bit    mon_busy_e;
   bit    mon_ok;
   int    mon_gc, mon_gs;
   real   mon_ec, mon_es, mon_mag, mon_a2;

   always @(negedge clk) begin
      if (mon_on) begin
         mon_gc     = int'(cos_out);
         mon_gs     = int'(sin_out);
         mon_busy_e = (cyc >= busy_lo) && (cyc <= busy_hi);
         chk(busy == mon_busy_e, "busy", busy, mon_busy_e);
         chk(!(out_last && !out_valid), "last_without_valid", out_last, 0);
         if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk(out_valid == 1'b1, "beat_valid", out_valid, 1);
            chk(out_last == mon_e.last, "beat_last", out_last, mon_e.last);
            if (mon_e.ex) begin
               mon_ec = real'(mon_e.ce);
               mon_es = real'(mon_e.se);
               chk(mon_gc == mon_e.ce, "cos_exact", mon_gc, mon_e.ce);
               chk(mon_gs == mon_e.se, "sin_exact", mon_gs, mon_e.se);
            end else begin
               mon_ec = ideal(mon_e.ph, 1'b0);
               mon_es = ideal(mon_e.ph, 1'b1);
               chk(near(mon_gc, mon_ec), "cos", mon_gc, int'(mon_ec));
               chk(near(mon_gs, mon_es), "sin", mon_gs, int'(mon_es));
               mon_mag = real'(mon_gc) * real'(mon_gc) + real'(mon_gs) * real'(mon_gs);
               mon_a2  = real'(A) * real'(A);
               mon_ok  = (mon_mag - mon_a2 <= 1.0e-4 * mon_a2) && (mon_a2 - mon_mag <= 1.0e-4 * mon_a2);
               chk(mon_ok, "magnitude", longint'(mon_mag), longint'(mon_a2));
            end
            hold_c = mon_ec;
            hold_s = mon_es;
         end else begin
            chk(out_valid == 1'b0, "no_beat", out_valid, 0);
            chk(near(mon_gc, hold_c), "hold_cos", mon_gc, int'(hold_c));
            chk(near(mon_gs, hold_s), "hold_sin", mon_gs, int'(hold_s));
         end
      end
   end

   initial begin
      vec_t tbl [7];
      int   r;
      tbl[0] = '{addr: 0,   cos_e: A,      sin_e: 0};
      tbl[1] = '{addr: 256, cos_e: 0,      sin_e: A};
      tbl[2] = '{addr: 512, cos_e: -A,     sin_e: 0};
      tbl[3] = '{addr: 768, cos_e: 0,      sin_e: -A};
      tbl[4] = '{addr: 128, cos_e: 92681,  sin_e: 92681};
      tbl[5] = '{addr: 896, cos_e: 92681,  sin_e: -92681};
      tbl[6] = '{addr: 384, cos_e: -92681, sin_e: 92681};

      reset_n  = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      addr     = '0;
      step     = '0;
      len      = '0;
      tick();
      tick();
      tick();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      mon_on  = 1'b1;
      idle(3);

      // Quadrant points and diagonals issued back to back.
      for (int i = 0; i < 7; i++)
         apply(1'b1, tbl[i].addr, 1'b0, 0, 0, 1'b1, tbl[i].cos_e, tbl[i].sin_e);
      idle(6);

      // Sweep across the wrap; direct requests during it must vanish.
      sweep(1000, 16, 4);
      for (int i = 0; i < 4; i++) direct(37 * i + 5);
      idle(8);

      // Zero-length start is ignored.
      sweep(100, 3, 0);
      idle(6);

      // start and in_valid together: only the sweep runs.
      apply(1'b1, 200, 1'b1, 5, 3, 1'b0, 0, 0);
      idle(8);

      // start held high: ignored while busy, re-accepted once busy drops.
      for (int i = 0; i < 5; i++) sweep(500, 100, 3);
      idle(10);

      // Full circle.
      sweep(0, 1, 1024);
      idle(1030);

      // Reset pulse while sweep beat 2 is on the outputs.
      sweep(50, 7, 8);
      idle(6);
      reset_n = 1'b0;
      exp_q.delete();
      busy_lo = 1;
      busy_hi = 0;
      hold_c  = 0.0;
      hold_s  = 0.0;
      #1;
      check_reset_outputs("midsweep_reset");
      tick();
      reset_n = 1'b1;
      idle(8);
      direct(300);
      idle(6);

      // Random mix of direct requests and sweeps.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 6)
            apply(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), 1'b1,
                  int'($urandom_range(0, N - 1)), int'($urandom_range(0, 12)), 1'b0, 0, 0);
         else
            apply(r < 60, int'($urandom_range(0, N - 1)), 1'b0, 0, 0, 1'b0, 0, 0);
      end
      idle(30);

      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
